// File: rtl/itype_alu_arbiter.sv
// Round-robin front end that shares one combinational I-type ALU among NREQ requesters.
// The winner's operands are latched, the ALU result is registered and returned tagged with its requester id.
module itype_alu_arbiter #(
   parameter  int NREQ = 2,
   parameter  int XLEN = 32,
   localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [NREQ*3-1:0]    req_funct3,
   input  logic [NREQ-1:0]      req_b30,
   input  logic [NREQ*XLEN-1:0] req_rv1,
   input  logic [NREQ*XLEN-1:0] req_imm,
   output logic [31:0]          alu_idata,
   output logic [XLEN-1:0]      alu_rv1,
   output logic [XLEN-1:0]      alu_imm,
   input  logic [XLEN-1:0]      alu_rd,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [XLEN-1:0]      rsp_data,
   output logic                 busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

   state_e          state_q,     state_d;
   logic [IDW-1:0]  rr_ptr_q,    rr_ptr_d;
   logic [2:0]      funct3_q,    funct3_d;
   logic            b30_q,       b30_d;
   logic [XLEN-1:0] rv1_q,       rv1_d;
   logic [XLEN-1:0] imm_q,       imm_d;
   logic [IDW-1:0]  id_q,        id_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]  rsp_id_q,    rsp_id_d;
   logic [XLEN-1:0] rsp_data_q,  rsp_data_d;

   logic            grant_found;
   logic [IDW-1:0]  grant_idx;
   logic [IDW-1:0]  scan_idx;

   // Scan starts one past the last winner so a persistent requester waits at most NREQ accepts.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int k = 1; k <= NREQ; k++) begin
         scan_idx = IDW'((32'(rr_ptr_q) + 32'(k)) % 32'(NREQ));
         if (!grant_found && req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   // Gated with reset so no requester sees an accept while the block is held in reset.
   always_comb begin
      req_ready = '0;
      if ((state_q == IDLE) && grant_found && reset) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      // NOTE: every variable gets a hold default first, so no path through the case infers a latch.
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      funct3_d    = funct3_q;
      b30_d       = b30_q;
      rv1_d       = rv1_q;
      imm_d       = imm_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_data_d  = rsp_data_q;
      case (state_q)
         IDLE: begin
            if (grant_found) begin
               funct3_d = req_funct3[3*grant_idx +: 3];
               b30_d    = req_b30[grant_idx];
               rv1_d    = req_rv1[XLEN*grant_idx +: XLEN];
               imm_d    = req_imm[XLEN*grant_idx +: XLEN];
               id_d     = grant_idx;
               rr_ptr_d = grant_idx;
               state_d  = EXEC;
            end
         end
         EXEC: begin
            rsp_data_d  = alu_rd;
            rsp_id_d    = id_q;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         rr_ptr_q    <= IDW'(NREQ - 1);
         funct3_q    <= '0;
         b30_q       <= 1'b0;
         rv1_q       <= '0;
         imm_q       <= '0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         funct3_q    <= funct3_d;
         b30_q       <= b30_d;
         rv1_q       <= rv1_d;
         imm_q       <= imm_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   assign alu_idata = {1'b0, b30_q, 15'b0, funct3_q, 5'b0, OPCODE_OP_IMM};
   assign alu_rv1   = rv1_q;
   assign alu_imm   = imm_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_itype_alu_arbiter.sv
// Self-checking bench for itype_alu_arbiter: behavioural I-type ALU, cycle-level protocol model,
// expected-response queue filled on accept and drained by an independent monitor.
module tb_itype_alu_arbiter;

   localparam int NREQ = 2;
   localparam int XLEN = 32;
   localparam int IDW  = 1;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [NREQ-1:0]      req_valid;
   logic [NREQ-1:0]      req_ready;
   logic [NREQ*3-1:0]    req_funct3;
   logic [NREQ-1:0]      req_b30;
   logic [NREQ*XLEN-1:0] req_rv1;
   logic [NREQ*XLEN-1:0] req_imm;
   logic [31:0]          alu_idata;
   logic [XLEN-1:0]      alu_rv1;
   logic [XLEN-1:0]      alu_imm;
   logic [XLEN-1:0]      alu_rd;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [IDW-1:0]       rsp_id;
   logic [XLEN-1:0]      rsp_data;
   logic                 busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   itype_alu_arbiter #(.NREQ(NREQ), .XLEN(XLEN)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_funct3 (req_funct3),
      .req_b30    (req_b30),
      .req_rv1    (req_rv1),
      .req_imm    (req_imm),
      .alu_idata  (alu_idata),
      .alu_rv1    (alu_rv1),
      .alu_imm    (alu_imm),
      .alu_rd     (alu_rd),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_data   (rsp_data),
      .busy       (busy)
   );

   // Architectural meaning of each I-type operation.
   function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic b30,
                                           input logic [31:0] a, input logic [31:0] b);
      int unsigned sh = b[4:0];
      case (f3)
         3'd0:    return a + b;
         3'd1:    return a << sh;
         3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         3'd3:    return (a < b) ? 32'd1 : 32'd0;
         3'd4:    return a ^ b;
         3'd5:    return b30 ? 32'($signed(a) >>> sh) : (a >> sh);
         3'd6:    return a | b;
         default: return a & b;
      endcase
   endfunction

   // Stand-in for the I_type unit: combinational from the arbiter's ALU-side outputs.
   always_comb alu_rd = ref_alu(alu_idata[14:12], alu_idata[30], alu_rv1, alu_imm);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum int {M_IDLE, M_EXEC, M_RESP} mstate_e;
   typedef struct {
      int          id;
      logic [31:0] data;
   } exp_t;

   mstate_e         m_state = M_IDLE;
   int              m_last = NREQ - 1;
   int              m_accepts = 0;
   logic [NREQ-1:0] m_acc = '0;
   exp_t            sb[$];

   function automatic int pick(input logic [NREQ-1:0] v, input int last);
      for (int k = 1; k <= NREQ; k++) begin
         if (v[(last + k) % NREQ]) return (last + k) % NREQ;
      end
      return -1;
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_state <= M_IDLE;
         m_last  <= NREQ - 1;
         m_acc   <= '0;
         sb.delete();
      end else begin
         m_acc <= '0;
         case (m_state)
            M_IDLE: begin
               automatic int g = pick(req_valid, m_last);
               if (g >= 0) begin
                  sb.push_back(exp_t'{id: g,
                     data: ref_alu(req_funct3[3*g +: 3], req_b30[g],
                                   req_rv1[XLEN*g +: XLEN], req_imm[XLEN*g +: XLEN])});
                  m_acc[g]  <= 1'b1;
                  m_last    <= g;
                  m_accepts <= m_accepts + 1;
                  m_state   <= M_EXEC;
               end
            end
            M_EXEC:  m_state <= M_RESP;
            default: if (rsp_ready) m_state <= M_IDLE;
         endcase
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin : monitor
      automatic int              g = -1;
      automatic logic [NREQ-1:0] exp_ready = '0;
      if (reset && (m_state == M_IDLE)) g = pick(req_valid, m_last);
      if (g >= 0) exp_ready[g] = 1'b1;
      check("req_ready", req_ready, exp_ready);
      check("busy", busy, m_state != M_IDLE);
      check("rsp_valid", rsp_valid, m_state == M_RESP);
      if (m_state == M_EXEC) check("alu_opcode", alu_idata[6:0], 7'b0010011);
      if (rsp_valid) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL sb_unexpected: got response id %0d data %h, expected no response", rsp_id, rsp_data);
         end else begin
            check("sb_id", rsp_id, sb[0].id);
            check("sb_data", rsp_data, sb[0].data);
            if (rsp_ready) void'(sb.pop_front());
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_req(input int id, input logic [2:0] f3, input logic b30,
                          input logic [31:0] a, input logic [31:0] b);
      req_funct3[3*id +: 3]  = f3;
      req_b30[id]            = b30;
      req_rv1[XLEN*id +: XLEN] = a;
      req_imm[XLEN*id +: XLEN] = b;
   endtask

   task automatic wait_grant(input string name, input int id);
      bit ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         ok = req_ready[id];
      end
      check(name, ok, 1'b1);
   endtask

   task automatic wait_rsp(input string name, output int lat);
      bit ok = 1'b0;
      lat = 0;
      for (int c = 0; c < 20 && !ok; c++) begin
         @(negedge clk);
         lat++;
         ok = rsp_valid;
      end
      check(name, ok, 1'b1);
   endtask

   task automatic drain(input string name);
      bit idle = 1'b0;
      rsp_ready = 1'b1;
      for (int c = 0; c < 40 && !idle; c++) begin
         @(negedge clk);
         idle = !busy && !rsp_valid;
      end
      check(name, idle, 1'b1);
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #2 reset = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
   endtask

   task automatic do_op(input string name, input int id, input logic [2:0] f3, input logic b30,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
      int lat;
      @(posedge clk);
      #1;
      set_req(id, f3, b30, a, b);
      req_valid[id] = 1'b1;
      rsp_ready     = 1'b1;
      wait_grant({name, "_grant"}, id);
      @(posedge clk);
      #1 req_valid[id] = 1'b0;
      wait_rsp({name, "_rsp"}, lat);
      check({name, "_latency"}, lat, 2);
      check({name, "_id"}, rsp_id, id);
      check({name, "_data"}, rsp_data, exp);
      @(posedge clk);
   endtask

   task automatic t3_round_robin();
      int gseq[4] = '{-1, -1, -1, -1};
      int iseq[4] = '{-1, -1, -1, -1};
      int ng = 0;
      int ni = 0;
      pulse_reset();
      @(posedge clk);
      #1;
      set_req(0, 3'b010, 1'b0, 32'd989, 32'd295);
      set_req(1, 3'b011, 1'b0, 32'd980, 32'd533);
      rsp_ready = 1'b1;
      req_valid = 2'b11;
      for (int c = 0; c < 40 && (ng < 4 || ni < 4); c++) begin
         @(negedge clk);
         if (req_ready != '0 && ng < 4) begin
            gseq[ng] = req_ready[1] ? 1 : 0;
            ng++;
         end
         if (rsp_valid && rsp_ready && ni < 4) begin
            iseq[ni] = int'(rsp_id);
            check("t3_data", rsp_data, 32'd0);
            ni++;
         end
      end
      for (int k = 0; k < 4; k++) begin
         check("t3_grant_seq", gseq[k], k % 2);
         check("t3_id_seq", iseq[k], k % 2);
      end
      @(posedge clk);
      #1 req_valid = '0;
      drain("t3_drain");
   endtask

   task automatic t4_backpressure();
      int lat;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      set_req(0, 3'b000, 1'b0, 32'd7, 32'hFFFF_FFFD);
      req_valid = 2'b01;
      wait_grant("t4_grant0", 0);
      @(posedge clk);
      #1;
      set_req(1, 3'b110, 1'b0, 32'h0000_00F0, 32'h0000_000F);
      req_valid = 2'b10;
      wait_rsp("t4_rsp", lat);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check("t4_hold_valid", rsp_valid, 1'b1);
         check("t4_hold_data", rsp_data, 32'd4);
         check("t4_hold_id", rsp_id, 0);
         check("t4_hold_ready", req_ready, 2'b00);
         check("t4_hold_busy", busy, 1'b1);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      @(negedge clk);
      check("t4_pre_handshake_valid", rsp_valid, 1'b1);
      @(negedge clk);
      check("t4_post_handshake_valid", rsp_valid, 1'b0);
      check("t4_next_grant", req_ready, 2'b10);
      @(posedge clk);
      #1 req_valid = '0;
      drain("t4_drain");
   endtask

   task automatic t5_reset_midop();
      int lat;
      // reset while the op is in EXEC
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      set_req(0, 3'b100, 1'b0, 32'h0000_1234, 32'h0000_00FF);
      req_valid = 2'b01;
      wait_grant("t5_grant_a", 0);
      @(posedge clk);
      #1 check("t5_exec_busy", busy, 1'b1);
      #1 reset = 1'b0;
      #1;
      check("t5_exec_rst_valid", rsp_valid, 1'b0);
      check("t5_exec_rst_busy", busy, 1'b0);
      check("t5_exec_rst_ready", req_ready, 2'b00);
      req_valid = '0;
      @(negedge clk);
      #2 reset = 1'b1;
      // both request after release: requester 0 must win
      @(posedge clk);
      #1;
      set_req(0, 3'b111, 1'b0, 32'hF0F0_F0F0, 32'hFFFF_FF0F);
      set_req(1, 3'b001, 1'b0, 32'h0000_0003, 32'h0000_0004);
      req_valid = 2'b11;
      @(negedge clk);
      check("t5_first_grant_a", req_ready, 2'b01);
      @(posedge clk);
      #1 req_valid = '0;
      wait_rsp("t5_resp_reached", lat);
      // reset while the result is held in RESP
      #2 reset = 1'b0;
      #1;
      check("t5_resp_rst_valid", rsp_valid, 1'b0);
      check("t5_resp_rst_busy", busy, 1'b0);
      @(negedge clk);
      #2 reset = 1'b1;
      @(posedge clk);
      #1 req_valid = 2'b11;
      @(negedge clk);
      check("t5_first_grant_b", req_ready, 2'b01);
      @(posedge clk);
      #1 req_valid = '0;
      drain("t5_drain");
   endtask

   task automatic t6_random();
      int start = m_accepts;
      int cyc = 0;
      logic [11:0] imm12;
      logic [31:0] imm;
      rsp_ready = 1'b1;
      while ((m_accepts - start) < 1000 && cyc < 20000) begin
         @(posedge clk);
         #1;
         cyc++;
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || m_acc[i]) begin
               if ($urandom_range(0, 99) < 60) begin
                  imm12 = 12'($urandom_range(0, 4095));
                  imm   = {{20{imm12[11]}}, imm12};
                  if ($urandom_range(0, 7) == 0) imm = 32'd750;
                  set_req(i, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), $urandom(), imm);
                  req_valid[i] = 1'b1;
               end else begin
                  req_valid[i] = 1'b0;
               end
            end else if ($urandom_range(0, 99) < 2) begin
               req_valid[i] = 1'b0;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
      end
      check("t6_ops_done", (m_accepts - start) >= 1000, 1'b1);
      @(posedge clk);
      #1 req_valid = '0;
      drain("t6_drain");
   endtask

   // ---------------- main sequence ----------------
   initial begin
      reset      = 1'b0;
      req_valid  = '0;
      req_funct3 = '0;
      req_b30    = '0;
      req_rv1    = '0;
      req_imm    = '0;
      rsp_ready  = 1'b0;
      repeat (2) @(negedge clk);
      req_valid = '1;
      @(negedge clk);
      #1;
      check("rst_rsp_valid", rsp_valid, 1'b0);
      check("rst_req_ready", req_ready, 2'b00);
      check("rst_busy", busy, 1'b0);
      check("rst_alu_idata", alu_idata, 32'h0000_0013);
      check("rst_rsp_data", rsp_data, 32'd0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_alu_rv1", alu_rv1, 32'd0);
      check("rst_alu_imm", alu_imm, 32'd0);
      req_valid = '0;
      #1 reset = 1'b1;

      do_op("t1_addi", 0, 3'b000, 1'b0, 32'h4000_0000, 32'h4000_0000, 32'h8000_0000);
      do_op("t2_srai", 1, 3'b101, 1'b1, 32'hFFFF_FFFB, 32'd5, 32'hFFFF_FFFF);
      do_op("t2_srli", 1, 3'b101, 1'b0, 32'hFFFF_FFFB, 32'd5, 32'h07FF_FFFF);
      do_op("slli_750", 0, 3'b001, 1'b0, 32'd1, 32'd750, 32'h0000_4000);
      do_op("slti_neg", 1, 3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1);
      do_op("sltiu_big", 0, 3'b011, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0);

      t3_round_robin();
      t4_backpressure();
      t5_reset_midop();
      t6_random();

      check("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
